// File: rtl/cache_arbiter_pkg.sv
// Shared types for the mp4 memory-side line arbiter: FSM states, grant
// identities and the line geometry used to align physical addresses.
package cache_arbiter_pkg;

    localparam int unsigned CA_LINE_W        = 256;
    localparam int unsigned CA_ADDR_W        = 32;
    localparam int unsigned LINE_OFFSET_BITS = $clog2(CA_LINE_W / 8);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } arb_state_t;

    typedef enum logic {
        GRANT_I = 1'b0,
        GRANT_D = 1'b1
    } arb_grant_t;

endpackage

// File: rtl/cache_arbiter.sv
// Round-robin arbiter between icache and dcache for the single line port of
// the cacheline adaptor; one 256-bit transaction in flight at a time.
module cache_arbiter
    import cache_arbiter_pkg::*;
#(
    parameter int unsigned LINE_W = CA_LINE_W,
    parameter int unsigned ADDR_W = CA_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_pmem_read,
    input  logic [ADDR_W-1:0] i_pmem_address,
    output logic [LINE_W-1:0] i_pmem_rdata,
    output logic              i_pmem_resp,
    input  logic              d_pmem_read,
    input  logic              d_pmem_write,
    input  logic [ADDR_W-1:0] d_pmem_address,
    input  logic [LINE_W-1:0] d_pmem_wdata,
    output logic [LINE_W-1:0] d_pmem_rdata,
    output logic              d_pmem_resp,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp,
    output logic [31:0]       i_grant_count,
    output logic [31:0]       d_grant_count
);

    localparam logic [ADDR_W-1:0] OFFSET_MASK = ADDR_W'((LINE_W / 8) - 1);

    function automatic logic [ADDR_W-1:0] line_align(input logic [ADDR_W-1:0] addr);
        return addr & ~OFFSET_MASK;
    endfunction

    arb_state_t        state_r;
    arb_grant_t        last_grant_r;
    logic              cmd_read_r;
    logic              cmd_write_r;
    logic [ADDR_W-1:0] addr_r;
    logic [LINE_W-1:0] wdata_r;
    logic [31:0]       i_count_r;
    logic [31:0]       d_count_r;
    logic              d_req_s;
    logic              grant_i_s;
    logic              grant_d_s;

    assign d_req_s = d_pmem_read | d_pmem_write;

    // Grant selection seen from IDLE: under contention favour whoever was not served last.
    always_comb begin
        grant_i_s = 1'b0;
        grant_d_s = 1'b0;
        if (i_pmem_read && (!d_req_s || (last_grant_r == GRANT_D))) begin
            grant_i_s = 1'b1;
        end else if (d_req_s) begin
            grant_d_s = 1'b1;
        end else begin
            grant_i_s = 1'b0;
            grant_d_s = 1'b0;
        end
    end

    // Arbitration FSM, request registers and per-requester completion counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            last_grant_r <= GRANT_D;
            cmd_read_r   <= 1'b0;
            cmd_write_r  <= 1'b0;
            addr_r       <= '0;
            wdata_r      <= '0;
            i_count_r    <= 32'd0;
            d_count_r    <= 32'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (grant_i_s) begin
                        state_r     <= SERVE_I;
                        cmd_read_r  <= 1'b1;
                        cmd_write_r <= 1'b0;
                        addr_r      <= line_align(i_pmem_address);
                    end else if (grant_d_s) begin
                        // A simultaneous read+write from the dcache is a writeback.
                        state_r     <= SERVE_D;
                        cmd_read_r  <= ~d_pmem_write;
                        cmd_write_r <= d_pmem_write;
                        addr_r      <= line_align(d_pmem_address);
                        wdata_r     <= d_pmem_wdata;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                SERVE_I: begin
                    if (pmem_resp) begin
                        state_r      <= IDLE;
                        cmd_read_r   <= 1'b0;
                        cmd_write_r  <= 1'b0;
                        last_grant_r <= GRANT_I;
                        i_count_r    <= i_count_r + 32'd1;
                    end else begin
                        state_r <= SERVE_I;
                    end
                end
                SERVE_D: begin
                    if (pmem_resp) begin
                        state_r      <= IDLE;
                        cmd_read_r   <= 1'b0;
                        cmd_write_r  <= 1'b0;
                        last_grant_r <= GRANT_D;
                        d_count_r    <= d_count_r + 32'd1;
                    end else begin
                        state_r <= SERVE_D;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    cmd_read_r  <= 1'b0;
                    cmd_write_r <= 1'b0;
                end
            endcase
        end
    end

    // Response is a zero-latency pass-through, suppressed while reset is applied.
    assign i_pmem_resp   = ~rst & pmem_resp & (state_r == SERVE_I);
    assign d_pmem_resp   = ~rst & pmem_resp & (state_r == SERVE_D);
    assign i_pmem_rdata  = pmem_rdata;
    assign d_pmem_rdata  = pmem_rdata;

    assign pmem_read     = cmd_read_r;
    assign pmem_write    = cmd_write_r;
    assign pmem_address  = addr_r;
    assign pmem_wdata    = wdata_r;
    assign i_grant_count = i_count_r;
    assign d_grant_count = d_count_r;

endmodule

// File: tb/tb_cache_arbiter.sv
// Self-checking bench for cache_arbiter: directed scenarios plus randomized
// cache/adaptor traffic compared against a transaction-level reference model.
module tb_cache_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic         i_pmem_read;
    logic [31:0]  i_pmem_address;
    logic [255:0] i_pmem_rdata;
    logic         i_pmem_resp;
    logic         d_pmem_read;
    logic         d_pmem_write;
    logic [31:0]  d_pmem_address;
    logic [255:0] d_pmem_wdata;
    logic [255:0] d_pmem_rdata;
    logic         d_pmem_resp;
    logic         pmem_read;
    logic         pmem_write;
    logic [31:0]  pmem_address;
    logic [255:0] pmem_wdata;
    logic [255:0] pmem_rdata;
    logic         pmem_resp;
    logic [31:0]  i_grant_count;
    logic [31:0]  d_grant_count;

    cache_arbiter dut (
        .clk(clk), .rst(rst),
        .i_pmem_read(i_pmem_read), .i_pmem_address(i_pmem_address),
        .i_pmem_rdata(i_pmem_rdata), .i_pmem_resp(i_pmem_resp),
        .d_pmem_read(d_pmem_read), .d_pmem_write(d_pmem_write),
        .d_pmem_address(d_pmem_address), .d_pmem_wdata(d_pmem_wdata),
        .d_pmem_rdata(d_pmem_rdata), .d_pmem_resp(d_pmem_resp),
        .pmem_read(pmem_read), .pmem_write(pmem_write),
        .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
        .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
        .i_grant_count(i_grant_count), .d_grant_count(d_grant_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: who owns the port (0 none, 1 icache, 2 dcache) and the
    // transaction it is carrying, updated once per clock edge.
    int           m_owner;
    bit           m_last_was_i;
    logic         m_read, m_write;
    logic [31:0]  m_addr;
    logic [255:0] m_wdata;
    logic [31:0]  m_ci, m_cd;
    logic         e_ir, e_dr;
    logic         seen_ir, seen_dr;
    logic [255:0] seen_irdata, seen_drdata;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [255:0] rand_line();
        logic [255:0] v;
        for (int k = 0; k < 8; k++) v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic model_edge();
        bit want_i, want_d;
        int winner;
        if (rst) begin
            m_owner = 0; m_last_was_i = 1'b0; m_read = 1'b0; m_write = 1'b0;
            m_addr = 32'd0; m_wdata = 256'd0; m_ci = 32'd0; m_cd = 32'd0;
        end else if (m_owner == 0) begin
            want_i = i_pmem_read;
            want_d = d_pmem_read | d_pmem_write;
            winner = 0;
            if (want_i && want_d) winner = m_last_was_i ? 2 : 1;
            else if (want_i)      winner = 1;
            else if (want_d)      winner = 2;
            if (winner == 1) begin
                m_owner = 1; m_read = 1'b1; m_write = 1'b0;
                m_addr = {i_pmem_address[31:5], 5'd0};
            end else if (winner == 2) begin
                m_owner = 2; m_write = d_pmem_write; m_read = !d_pmem_write;
                m_addr = {d_pmem_address[31:5], 5'd0}; m_wdata = d_pmem_wdata;
            end
        end else if (pmem_resp) begin
            if (m_owner == 1) m_ci = m_ci + 32'd1;
            else              m_cd = m_cd + 32'd1;
            m_last_was_i = (m_owner == 1);
            m_owner = 0; m_read = 1'b0; m_write = 1'b0;
        end
    endtask

    // One clock: check the zero-latency response path, advance the model, then
    // check the registered outputs on the falling edge.
    task automatic step();
        #1;
        e_ir = !rst && (m_owner == 1) && pmem_resp;
        e_dr = !rst && (m_owner == 2) && pmem_resp;
        chk("i_resp", {255'd0, i_pmem_resp}, {255'd0, e_ir});
        chk("d_resp", {255'd0, d_pmem_resp}, {255'd0, e_dr});
        chk("i_rdata", i_pmem_rdata, pmem_rdata);
        chk("d_rdata", d_pmem_rdata, pmem_rdata);
        seen_ir = i_pmem_resp; seen_dr = d_pmem_resp;
        seen_irdata = i_pmem_rdata; seen_drdata = d_pmem_rdata;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk("pmem_read", {255'd0, pmem_read}, {255'd0, m_read});
        chk("pmem_write", {255'd0, pmem_write}, {255'd0, m_write});
        chk("pmem_address", {224'd0, pmem_address}, {224'd0, m_addr});
        chk("pmem_wdata", pmem_wdata, m_wdata);
        chk("i_count", {224'd0, i_grant_count}, {224'd0, m_ci});
        chk("d_count", {224'd0, d_grant_count}, {224'd0, m_cd});
    endtask

    task automatic quiet_inputs();
        i_pmem_read = 1'b0; d_pmem_read = 1'b0; d_pmem_write = 1'b0;
        pmem_resp = 1'b0;
    endtask

    task automatic do_reset();
        quiet_inputs();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    logic [255:0] line_a5;
    logic [255:0] wline;
    logic         i_ack, d_ack, busy;
    int           dly;

    initial begin
        rst = 1'b1;
        i_pmem_address = 32'd0; d_pmem_address = 32'd0;
        d_pmem_wdata = 256'd0; pmem_rdata = 256'd0;
        quiet_inputs();
        m_owner = 0; m_last_was_i = 1'b0; m_read = 1'b0; m_write = 1'b0;
        m_addr = 32'd0; m_wdata = 256'd0; m_ci = 32'd0; m_cd = 32'd0;
        @(negedge clk);
        do_reset();
        chk("reset_cmd", {254'd0, pmem_read, pmem_write}, 256'd0);
        chk("reset_counts", {192'd0, i_grant_count, d_grant_count}, 256'd0);

        // Single icache fill.
        i_pmem_read = 1'b1; i_pmem_address = 32'h0000_0064;
        step();
        chk("i_fill_read", {255'd0, pmem_read}, 256'd1);
        chk("i_fill_addr", {224'd0, pmem_address}, 256'h60);
        line_a5 = {32{8'hA5}};
        pmem_resp = 1'b1; pmem_rdata = line_a5;
        step();
        chk("i_fill_resp", {254'd0, seen_ir, seen_dr}, 256'd2);
        chk("i_fill_rdata", seen_irdata, line_a5);
        chk("i_fill_count", {224'd0, i_grant_count}, 256'd1);
        quiet_inputs();
        step();

        // Contention rounds straight after reset: I, D, I, D.
        do_reset();
        i_pmem_address = 32'h0000_0100; d_pmem_address = 32'h0000_0200;
        for (int k = 0; k < 4; k++) begin
            i_pmem_read = 1'b1; d_pmem_read = 1'b1;
            step();
            chk("contend_addr", {224'd0, pmem_address}, (k % 2 == 0) ? 256'h100 : 256'h200);
            pmem_resp = 1'b1; pmem_rdata = rand_line();
            step();
            chk("contend_resp", {254'd0, seen_ir, seen_dr}, (k % 2 == 0) ? 256'd2 : 256'd1);
            quiet_inputs();
            step();
        end

        // Writeback with wdata latched at grant.
        wline = {8{32'h1234_5678}};
        d_pmem_write = 1'b1; d_pmem_address = 32'h0000_1000; d_pmem_wdata = wline;
        step();
        chk("wb_write", {254'd0, pmem_read, pmem_write}, 256'd1);
        chk("wb_wdata", pmem_wdata, wline);
        d_pmem_wdata = ~wline;
        step();
        chk("wb_wdata_held", pmem_wdata, wline);
        pmem_resp = 1'b1;
        step();
        quiet_inputs();
        step();

        // Dcache read and write together resolve to a write.
        d_pmem_read = 1'b1; d_pmem_write = 1'b1; d_pmem_wdata = rand_line();
        step();
        chk("rw_is_write", {254'd0, pmem_read, pmem_write}, 256'd1);
        pmem_resp = 1'b1;
        step();
        quiet_inputs();
        step();

        // Reset three cycles into a dcache read; responses around it are dropped.
        d_pmem_read = 1'b1; d_pmem_address = 32'h0000_0ABC;
        step(); step(); step();
        rst = 1'b1; pmem_resp = 1'b1;
        step();
        chk("rst_resp_dropped", {255'd0, seen_dr}, 256'd0);
        chk("rst_cmd", {254'd0, pmem_read, pmem_write}, 256'd0);
        chk("rst_counts", {192'd0, i_grant_count, d_grant_count}, 256'd0);
        rst = 1'b0; d_pmem_read = 1'b0;
        step();
        chk("late_resp", {254'd0, seen_ir, seen_dr}, 256'd0);
        quiet_inputs();
        step();

        // Counter wrap.
        force dut.d_count_r = 32'hFFFF_FFFF;
        #1;
        release dut.d_count_r;
        m_cd = 32'hFFFF_FFFF;
        chk("wrap_preset", {224'd0, d_grant_count}, 256'hFFFF_FFFF);
        d_pmem_read = 1'b1;
        step();
        pmem_resp = 1'b1;
        step();
        chk("wrap_zero", {224'd0, d_grant_count}, 256'd0);
        quiet_inputs();
        step();

        // Randomized traffic from both caches against a variable-latency adaptor.
        i_ack = 1'b0; d_ack = 1'b0; busy = 1'b0; dly = 0;
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 299) == 0);
            pmem_resp = 1'b0;
            if (rst) busy = 1'b0;
            if (!busy && (m_read || m_write)) begin
                busy = 1'b1;
                dly = $urandom_range(0, 3);
            end
            if (busy) begin
                if (dly == 0) begin
                    pmem_resp = 1'b1; pmem_rdata = rand_line(); busy = 1'b0;
                end else begin
                    dly--;
                end
            end else if ($urandom_range(0, 15) == 0) begin
                pmem_resp = 1'b1; pmem_rdata = rand_line();
            end
            if (rst || i_ack) i_pmem_read = 1'b0;
            else if (!i_pmem_read && $urandom_range(0, 3) == 0) begin
                i_pmem_read = 1'b1; i_pmem_address = $urandom;
            end
            if (rst || d_ack) begin
                d_pmem_read = 1'b0; d_pmem_write = 1'b0;
            end else if (!(d_pmem_read || d_pmem_write) && $urandom_range(0, 3) == 0) begin
                case ($urandom_range(1, 3))
                    1:       begin d_pmem_read = 1'b1; d_pmem_write = 1'b0; end
                    2:       begin d_pmem_read = 1'b0; d_pmem_write = 1'b1; end
                    default: begin d_pmem_read = 1'b1; d_pmem_write = 1'b1; end
                endcase
                d_pmem_address = $urandom; d_pmem_wdata = rand_line();
            end else if ((d_pmem_read || d_pmem_write) && $urandom_range(0, 3) == 0) begin
                d_pmem_wdata = rand_line();
            end
            step();
            i_ack = e_ir;
            d_ack = e_dr;
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/cache_arbiter.md
# cache_arbiter

Arbitrates the single physical-memory line port between the instruction cache and the data cache in the mp4 pipelined core. It sits between the two caches' miss/writeback ports and the cacheline adaptor that drives the burst memory interface. It serves one 256-bit line transaction at a time, alternates grants round-robin under contention, and routes the response back only to the granted cache. Per-requester grant counters support performance debug.

## Interface
- LINE_W, 256, cache line width in bits
- ADDR_W, 32, physical address width
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- i_pmem_read  in  1  icache line-fill request
- i_pmem_address  in  ADDR_W  icache line address
- i_pmem_rdata  out  LINE_W  fill data to icache
- i_pmem_resp  out  1  icache transaction done
- d_pmem_read  in  1  dcache line-fill request
- d_pmem_write  in  1  dcache writeback request
- d_pmem_address  in  ADDR_W  dcache line address
- d_pmem_wdata  in  LINE_W  dcache writeback data
- d_pmem_rdata  out  LINE_W  fill data to dcache
- d_pmem_resp  out  1  dcache transaction done
- pmem_read  out  1  read request to cacheline adaptor
- pmem_write  out  1  write request to cacheline adaptor
- pmem_address  out  ADDR_W  line-aligned address to adaptor
- pmem_wdata  out  LINE_W  writeback line to adaptor
- pmem_rdata  in  LINE_W  line from adaptor
- pmem_resp  in  1  adaptor transaction done
- i_grant_count  out  32  completed icache transactions
- d_grant_count  out  32  completed dcache transactions

## Operation
- FSM states: IDLE, SERVE_I, SERVE_D.
- IDLE, icache request only: go to SERVE_I. Dcache request only: go to SERVE_D. Both: grant the requester not served last (last_grant register; reset value = D, so the first contended grant goes to I). Neither: stay.
- On grant, latch the command, the address with the low log2(LINE_W/8) bits cleared, and the wdata (dcache only) into request registers. Downstream outputs are driven only from these registers.
- Dcache read and write both high: treat as write, i.e. writeback wins.
- In SERVE_x, hold pmem_read/pmem_write steady until pmem_resp. Upstream request inputs are ignored while serving.
- pmem_resp in SERVE_x:
  - x_pmem_resp = 1 and x_pmem_rdata = pmem_rdata, combinationally, in the same cycle.
  - Clear the downstream command registers.
  - Increment x_grant_count, wrapping modulo 2^32.
  - Update last_grant.
  - Go to IDLE.
- The non-granted requester always sees resp = 0. Its rdata is driven with pmem_rdata; it is don't-care.
- Requesters hold their request until their resp, and deassert it in the following cycle. This is the existing cache FSM contract.

## Timing
- Reset values: state IDLE, last_grant D, all request registers 0, pmem_read/pmem_write 0, both grant counts 0, both resp outputs 0.
- Request-to-downstream latency: request seen in IDLE in cycle N produces pmem_read/pmem_write high in cycle N+1.
- Response latency: 0 cycles, pmem_resp is passed straight through to the granted cache.
- Back-to-back transactions: pmem_resp in cycle M puts the FSM in IDLE in M+1. A pending request seen in M+1 is driven downstream in M+2. Minimum gap is 1 idle cycle.
- rst in any state, including mid-transaction: next cycle is IDLE with commands low. A pmem_resp arriving in the reset cycle is dropped. The adaptor shares the same rst.
- pmem_resp while in IDLE: ignored, no resp forwarded, counters unchanged.

## Structure
- Shared package (mp4 types package) holds:
  - arb_state_t enum {IDLE, SERVE_I, SERVE_D}
  - arb_grant_t enum {GRANT_I, GRANT_D}
  - localparam LINE_OFFSET_BITS = $clog2(LINE_W/8)
- No sub-module: a single FSM plus request registers and two counters.
- Instantiated in mp4 top between the caches and the cacheline adaptor.

## Test plan
- Icache read of 0x00000064 alone: pmem_read high one cycle later with pmem_address 0x00000060. Adaptor resp with line 0xA5..A5 gives i_pmem_resp = 1 and i_pmem_rdata = 0xA5..A5 the same cycle, d_pmem_resp = 0, and i_grant_count = 1.
- I and D reads asserted together right after reset: icache served first, then dcache after a 1-cycle gap. Repeating the contention gives order I, D, I, D.
- Dcache writeback to 0x00001000 with wdata 0x1234..: pmem_write high with the latched wdata. Changing d_pmem_wdata mid-transaction does not change pmem_wdata.
- d_pmem_read and d_pmem_write both high: a write is issued downstream and pmem_read stays 0.
- rst asserted 3 cycles into SERVE_D: next cycle IDLE, pmem_read/pmem_write 0, counters 0, and a late pmem_resp produces no upstream resp.
- Force d_grant_count to 0xFFFFFFFF and complete one dcache transaction: the count wraps to 0.
